// File: rtl/dbus_uncached_responder.sv
// rtl/dbus_uncached_responder.sv - CPU data-bus responder, one AXI4-lite-style transaction per load/store
// Optional feature macro: DBUS_WBUF_EN (one-entry posted write buffer).
module dbus_uncached_responder #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cpu_valid_i,
    input  logic                cpu_wr_i,
    input  logic [1:0]          cpu_size_i,
    input  logic [ADDR_W-1:0]   cpu_addr_i,
    input  logic [DATA_W/8-1:0] cpu_wstrb_i,
    input  logic [DATA_W-1:0]   cpu_wdata_i,
    output logic                cpu_busy_o,
    output logic [DATA_W-1:0]   cpu_rdata_o,
    output logic                ar_valid_o,
    input  logic                ar_ready_i,
    output logic [ADDR_W-1:0]   ar_addr_o,
    output logic [1:0]          ar_size_o,
    input  logic                r_valid_i,
    output logic                r_ready_o,
    input  logic [DATA_W-1:0]   r_data_i,
    output logic                aw_valid_o,
    input  logic                aw_ready_i,
    output logic [ADDR_W-1:0]   aw_addr_o,
    output logic [1:0]          aw_size_o,
    output logic                w_valid_o,
    input  logic                w_ready_i,
    output logic [DATA_W-1:0]   w_data_o,
    output logic [DATA_W/8-1:0] w_strb_o,
    input  logic                b_valid_i,
    output logic                b_ready_o
);
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   raddr_q, waddr_q;
    logic [1:0]          rsize_q, wsize_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic [DATA_W-1:0]   wdata_q, rdata_q;
    logic                ar_valid_q, r_ready_q, aw_valid_q, w_valid_q, b_ready_q;
    logic                aw_pend_d, w_pend_d, wbuf_free;

    // Write channels still owed a handshake after this cycle
    assign aw_pend_d = aw_valid_q & ~aw_ready_i;
    assign w_pend_d  = w_valid_q & ~w_ready_i;

`ifdef DBUS_WBUF_EN
    logic wb_full_q;
    assign wbuf_free = ~wb_full_q;
`else
    assign wbuf_free = 1'b1;
`endif

    assign cpu_busy_o  = (state_q == IDLE) ? cpu_valid_i : (state_q != DONE);
    assign cpu_rdata_o = rdata_q;
    assign ar_valid_o  = ar_valid_q;
    assign ar_addr_o   = raddr_q;
    assign ar_size_o   = rsize_q;
    assign r_ready_o   = r_ready_q;
    assign aw_valid_o  = aw_valid_q;
    assign aw_addr_o   = waddr_q;
    assign aw_size_o   = wsize_q;
    assign w_valid_o   = w_valid_q;
    assign w_data_o    = wdata_q;
    assign w_strb_o    = wstrb_q;
    assign b_ready_o   = b_ready_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            raddr_q    <= '0;
            waddr_q    <= '0;
            rsize_q    <= '0;
            wsize_q    <= '0;
            wstrb_q    <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            b_ready_q  <= 1'b0;
`ifdef DBUS_WBUF_EN
            wb_full_q  <= 1'b0;
`endif
        end else begin
            if (aw_valid_q && aw_ready_i) aw_valid_q <= 1'b0;
            if (w_valid_q && w_ready_i)   w_valid_q  <= 1'b0;
`ifdef DBUS_WBUF_EN
            // Buffered store drains independently of the request FSM
            if (wb_full_q && !aw_pend_d && !w_pend_d && !b_ready_q) b_ready_q <= 1'b1;
            if (b_ready_q && b_valid_i) begin
                b_ready_q <= 1'b0;
                wb_full_q <= 1'b0;
            end
`endif
            case (state_q)
                IDLE: begin
                    if (cpu_valid_i && wbuf_free) begin
                        if (cpu_wr_i) begin
                            waddr_q    <= cpu_addr_i;
                            wsize_q    <= cpu_size_i;
                            wstrb_q    <= cpu_wstrb_i;
                            wdata_q    <= cpu_wdata_i;
                            aw_valid_q <= 1'b1;
                            w_valid_q  <= 1'b1;
`ifdef DBUS_WBUF_EN
                            wb_full_q  <= 1'b1;
                            state_q    <= DONE;
`else
                            state_q    <= WR_REQ;
`endif
                        end else begin
                            raddr_q    <= cpu_addr_i;
                            rsize_q    <= cpu_size_i;
                            ar_valid_q <= 1'b1;
                            state_q    <= RD_ADDR;
                        end
                    end
                end
                RD_ADDR: begin
                    if (ar_ready_i) begin
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b1;
                        state_q    <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (r_valid_i) begin
                        rdata_q   <= r_data_i;
                        r_ready_q <= 1'b0;
                        state_q   <= DONE;
                    end
                end
                WR_REQ: begin
                    if (!aw_pend_d && !w_pend_d) begin
                        b_ready_q <= 1'b1;
                        state_q   <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (b_valid_i) begin
                        b_ready_q <= 1'b0;
                        state_q   <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dbus_uncached_responder.sv
// tb/tb_dbus_uncached_responder.sv - cycle-scheduled bench: timeline model of each transaction vs DUT
module tb_dbus_uncached_responder;
`ifdef DBUS_WBUF_EN
    localparam bit WBUF = 1'b1;
`else
    localparam bit WBUF = 1'b0;
`endif
    localparam int N = 4096;

    logic        clk_i = 1'b0, rst_i = 1'b1;
    logic        cpu_valid_i = 1'b0, cpu_wr_i = 1'b0;
    logic [1:0]  cpu_size_i = '0;
    logic [31:0] cpu_addr_i = '0, cpu_wdata_i = '0, r_data_i = '0;
    logic [3:0]  cpu_wstrb_i = '0;
    logic        ar_ready_i = 1'b0, r_valid_i = 1'b0, aw_ready_i = 1'b0, w_ready_i = 1'b0, b_valid_i = 1'b0;
    logic        cpu_busy_o, ar_valid_o, r_ready_o, aw_valid_o, w_valid_o, b_ready_o;
    logic [31:0] cpu_rdata_o, ar_addr_o, aw_addr_o, w_data_o;
    logic [1:0]  ar_size_o, aw_size_o;
    logic [3:0]  w_strb_o;

    dbus_uncached_responder dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_valid_i(cpu_valid_i), .cpu_wr_i(cpu_wr_i), .cpu_size_i(cpu_size_i),
        .cpu_addr_i(cpu_addr_i), .cpu_wstrb_i(cpu_wstrb_i), .cpu_wdata_i(cpu_wdata_i),
        .cpu_busy_o(cpu_busy_o), .cpu_rdata_o(cpu_rdata_o),
        .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o), .ar_size_o(ar_size_o),
        .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i),
        .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o), .aw_size_o(aw_size_o),
        .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o), .w_strb_o(w_strb_o),
        .b_valid_i(b_valid_i), .b_ready_o(b_ready_o)
    );

    always #5 clk_i = ~clk_i;

    // Per-cycle stimulus (d_*) and expected outputs (e_*)
    bit        d_rst[N], d_cv[N], d_wr[N], d_arr[N], d_rv[N], d_awr[N], d_wrdy[N], d_bv[N];
    bit [1:0]  d_size[N];
    bit [3:0]  d_strb[N];
    bit [31:0] d_addr[N], d_wdata[N], d_rdata[N];
    bit        e_busy[N], e_arv[N], e_rr[N], e_awv[N], e_wv[N], e_br[N];
    bit [31:0] e_rdata[N], e_araddr[N], e_awaddr[N], e_wdata[N];
    bit [1:0]  e_arsize[N], e_awsize[N];
    bit [3:0]  e_wstrb[N];

    int        c = 2, last_done = -10, last_t0 = 0, wb_free = 0, cur_cy = 0, end_cyc;
    bit [31:0] m_rdata = 32'h0;
    bit        running = 1'b0;
    int        n_checks = 0, n_errors = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cur_cy, act, exp);
        end
    endfunction

    task automatic clear(int cy);
        d_rst[cy] = 0; d_cv[cy] = 0; d_wr[cy] = 0; d_arr[cy] = 0; d_rv[cy] = 0; d_awr[cy] = 0;
        d_wrdy[cy] = 0; d_bv[cy] = 0; d_size[cy] = 0; d_strb[cy] = 0; d_addr[cy] = 0;
        d_wdata[cy] = 0; d_rdata[cy] = 0; e_busy[cy] = 0; e_arv[cy] = 0; e_rr[cy] = 0;
        e_awv[cy] = 0; e_wv[cy] = 0; e_br[cy] = 0; e_rdata[cy] = 0;
    endtask

    task automatic put_req(int cy, bit wr, bit [31:0] a, bit [1:0] s, bit [3:0] st, bit [31:0] wd);
        d_cv[cy] = 1; d_wr[cy] = wr; d_addr[cy] = a; d_size[cy] = s; d_strb[cy] = st; d_wdata[cy] = wd;
    endtask

    // Reset for one cycle at R: everything returns to idle, read data clears, slave forgets too
    task automatic do_reset(int r);
        for (int cy = c; cy < r; cy++) e_rdata[cy] = m_rdata;
        for (int cy = r; cy < r + 48; cy++) clear(cy);
        d_rst[r] = 1; m_rdata = 0; wb_free = 0; last_done = -10; c = r + 2;
    endtask

    task automatic add_idle(int n, bit junk);
        for (int cy = c; cy < c + n; cy++) begin
            e_rdata[cy] = m_rdata;
            if (junk && $urandom_range(0, 2) == 0) begin d_rv[cy] = 1; d_rdata[cy] = $urandom; end
            if (junk && cy >= wb_free && $urandom_range(0, 2) == 0) d_bv[cy] = 1;
        end
        c += n;
    endtask

    task automatic add_load(bit [31:0] a, bit [1:0] s, bit [31:0] data, int da, int dr, bit b2b, int rst_off);
        int t0, ta, tr;
        if (b2b && last_done == c - 1) put_req(c - 1, 0, a, s, 4'h0, 32'h0);
        t0 = (wb_free > c) ? wb_free : c;
        ta = t0 + 1 + da;
        tr = ta + 1 + dr;
        for (int cy = c; cy <= tr; cy++) begin
            put_req(cy, 0, a, s, 4'h0, 32'h0); e_busy[cy] = 1; e_rdata[cy] = m_rdata;
        end
        for (int cy = t0 + 1; cy <= ta; cy++) begin e_arv[cy] = 1; e_araddr[cy] = a; e_arsize[cy] = s; end
        for (int cy = ta + 1; cy <= tr; cy++) e_rr[cy] = 1;
        d_arr[ta] = 1; d_rv[tr] = 1; d_rdata[tr] = data;
        m_rdata = data; e_rdata[tr + 1] = data;
        last_t0 = t0; last_done = tr + 1; c = tr + 2;
        if (rst_off >= 0) do_reset(t0 + rst_off);
    endtask

    task automatic add_store(bit [31:0] a, bit [1:0] s, bit [3:0] st, bit [31:0] wd,
                             int daw, int dw, int db, bit b2b, int rst_off);
        int t0, taw, tw, tb0, tbh, td;
        if (b2b && last_done == c - 1) put_req(c - 1, 1, a, s, st, wd);
        t0  = (wb_free > c) ? wb_free : c;
        taw = t0 + 1 + daw;
        tw  = t0 + 1 + dw;
        tb0 = ((taw > tw) ? taw : tw) + 1;
        tbh = tb0 + db;
        td  = WBUF ? t0 + 1 : tbh + 1;
        for (int cy = c; cy < td; cy++) begin
            put_req(cy, 1, a, s, st, wd); e_busy[cy] = 1; e_rdata[cy] = m_rdata;
        end
        e_rdata[td] = m_rdata;
        for (int cy = t0 + 1; cy <= taw; cy++) begin e_awv[cy] = 1; e_awaddr[cy] = a; e_awsize[cy] = s; end
        for (int cy = t0 + 1; cy <= tw; cy++) begin e_wv[cy] = 1; e_wdata[cy] = wd; e_wstrb[cy] = st; end
        for (int cy = tb0; cy <= tbh; cy++) e_br[cy] = 1;
        d_awr[taw] = 1; d_wrdy[tw] = 1; d_bv[tbh] = 1;
        if (WBUF) wb_free = tbh + 1;
        last_t0 = t0; last_done = td; c = td + 1;
        if (rst_off >= 0) do_reset(t0 + rst_off);
    endtask

    always @(negedge clk_i) begin
        if (running) begin
            chk("cpu_busy", 32'(cpu_busy_o), 32'(e_busy[cur_cy]));
            chk("cpu_rdata", cpu_rdata_o, e_rdata[cur_cy]);
            chk("ar_valid", 32'(ar_valid_o), 32'(e_arv[cur_cy]));
            chk("r_ready", 32'(r_ready_o), 32'(e_rr[cur_cy]));
            chk("aw_valid", 32'(aw_valid_o), 32'(e_awv[cur_cy]));
            chk("w_valid", 32'(w_valid_o), 32'(e_wv[cur_cy]));
            chk("b_ready", 32'(b_ready_o), 32'(e_br[cur_cy]));
            if (e_arv[cur_cy]) begin
                chk("ar_addr", ar_addr_o, e_araddr[cur_cy]);
                chk("ar_size", 32'(ar_size_o), 32'(e_arsize[cur_cy]));
            end
            if (e_awv[cur_cy]) begin
                chk("aw_addr", aw_addr_o, e_awaddr[cur_cy]);
                chk("aw_size", 32'(aw_size_o), 32'(e_awsize[cur_cy]));
            end
            if (e_wv[cur_cy]) begin
                chk("w_data", w_data_o, e_wdata[cur_cy]);
                chk("w_strb", 32'(w_strb_o), 32'(e_wstrb[cur_cy]));
            end
        end
    end

    initial begin
        bit [31:0] a;
        bit [1:0]  s;
        bit        b2b;
        d_rst[0] = 1; d_rst[1] = 1;
        // T2: word load, AR ready after 2 cycles, R 3 cycles later
        add_load(32'hBFAF_0000, 2'd2, 32'hDEAD_BEEF, 2, 3, 0, -1);
        chk("model_t2_latency", 32'(last_done - last_t0), 32'd8);
        chk("model_t2_rdata", e_rdata[last_done], 32'hDEAD_BEEF);
        add_idle(4, 1);
        chk("model_t2_hold", e_rdata[c - 1], 32'hDEAD_BEEF);
        // T3: half store, AW ready one cycle before W ready
        add_store(32'h8000_0010, 2'd1, 4'b0011, 32'h0000_1234, 0, 1, 1, 0, -1);
        chk("model_t3_latency", 32'(last_done - last_t0), WBUF ? 32'd1 : 32'd5);
        chk("model_t3_rdata_kept", e_rdata[last_done], 32'hDEAD_BEEF);
        add_idle(2, 0);
        // T4: store then load, B delayed 5 cycles
        add_store(32'h0000_1000, 2'd2, 4'hF, 32'hCAFE_F00D, 0, 0, 5, 0, -1);
        add_load(32'h0000_2000, 2'd2, 32'h1357_9BDF, 1, 1, 1, -1);
        add_idle(3, 1);
        // T5: reset while in RD_DATA, then a normal load
        add_load(32'h0000_3000, 2'd0, 32'h0BAD_0BAD, 0, 3, 0, 3);
        add_load(32'h0000_3004, 2'd1, 32'h2468_ACE0, 1, 0, 0, -1);
        // T6: back-to-back zero-wait loads
        add_idle(2, 0);
        add_load(32'h0000_4000, 2'd2, 32'h1111_2222, 0, 0, 0, -1);
        chk("model_t6_latency", 32'(last_done - last_t0), 32'd3);
        add_load(32'h0000_4004, 2'd2, 32'h3333_4444, 0, 0, 1, -1);
        chk("model_t6_b2b_start", 32'(last_t0), 32'(last_done - 3));
        // T1: reset in the middle of a store
        add_idle(2, 0);
        add_store(32'h0000_5000, 2'd2, 4'hF, 32'h5555_AAAA, 2, 2, 2, 0, 2);
        // Random mix of loads and stores with random slave latencies
        for (int k = 0; k < 60; k++) begin
            b2b = 1'($urandom_range(0, 1));
            if (!b2b) add_idle($urandom_range(1, 3), 1);
            a = $urandom;
            s = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1)
                add_store(a, s, 4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 3), b2b, -1);
            else
                add_load(a, s, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), b2b, -1);
        end
        add_idle(20, 0);
        end_cyc = c;

        for (int cy = 0; cy < end_cyc; cy++) begin
            @(posedge clk_i);
            #1;
            cur_cy      = cy;
            running     = 1'b1;
            rst_i       = d_rst[cy];
            cpu_valid_i = d_cv[cy];
            cpu_wr_i    = d_wr[cy];
            cpu_size_i  = d_size[cy];
            cpu_addr_i  = d_addr[cy];
            cpu_wstrb_i = d_strb[cy];
            cpu_wdata_i = d_wdata[cy];
            ar_ready_i  = d_arr[cy];
            r_valid_i   = d_rv[cy];
            r_data_i    = d_rdata[cy];
            aw_ready_i  = d_awr[cy];
            w_ready_i   = d_wrdy[cy];
            b_valid_i   = d_bv[cy];
        end
        @(posedge clk_i);
        running = 1'b0;
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
